// File: rtl/joy_clk_pkg.sv
// joy_clk_pkg: shared constants and helpers for the joystick clock-enable generator
package joy_clk_pkg;
  localparam int JOY_CLK_NUM_CH_DEF  = 4;
  localparam int JOY_CLK_DIV_W_DEF   = 7;
  localparam int JOY_CLK_DEFAULT_DIV = 127;
  function automatic int joy_clk_sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/joy_clk_en_channel.sv
// joy_clk_en_channel: one programmable-divisor enable channel with shadowed divisor writes
module joy_clk_en_channel
  import joy_clk_pkg::*;
#(
  parameter int               DIV_W       = JOY_CLK_DIV_W_DEF,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(JOY_CLK_DEFAULT_DIV)
) (
  input  logic             clk_peripheral,
  input  logic             reset_n,
  input  logic             run,
  input  logic             restart,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_data,
  output logic             clk_en,
  output logic             pending
);
  logic [DIV_W-1:0] cnt_q, cnt_d, active_q, active_d, shadow_q, shadow_d, reload_val;
  logic             pend_q, pend_d, clk_en_q, clk_en_d, zero, reload;
  always_comb begin
    zero       = (cnt_q == '0);
    reload     = restart || (run && zero);
    // a write landing on a reload cycle bypasses the shadow entirely
    reload_val = wr ? wr_data : (pend_q ? shadow_q : active_q);
    cnt_d      = reload ? reload_val : (run ? cnt_q - DIV_W'(1) : cnt_q);
    active_d   = reload ? reload_val : ((!run && pend_q) ? shadow_q : active_q);
    shadow_d   = wr ? wr_data : shadow_q;
    pend_d     = !reload && (wr || (run && pend_q));
    clk_en_d   = run && !restart && zero;
  end
  always_ff @(posedge clk_peripheral) begin
    if (!reset_n) begin
      cnt_q    <= DEFAULT_DIV;
      active_q <= DEFAULT_DIV;
      shadow_q <= DEFAULT_DIV;
      pend_q   <= 1'b0;
      clk_en_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      clk_en_q <= clk_en_d;
    end
  end
  assign clk_en  = clk_en_q;
  assign pending = pend_q;
endmodule

// File: rtl/joy_clock_enable_gen.sv
// joy_clock_enable_gen: multi-channel clock-enable generator with run-time divisor writes
module joy_clock_enable_gen
  import joy_clk_pkg::*;
#(
  parameter int NUM_CH      = JOY_CLK_NUM_CH_DEF,
  parameter int DIV_W       = JOY_CLK_DIV_W_DEF,
  parameter int DEFAULT_DIV = JOY_CLK_DEFAULT_DIV
) (
  input  logic                               clk_peripheral,
  input  logic                               reset_n,
  input  logic [NUM_CH-1:0]                  run,
  input  logic                               restart,
  input  logic                               div_wr,
  input  logic [joy_clk_sel_w(NUM_CH)-1:0]   div_sel,
  input  logic [DIV_W-1:0]                   div_data,
  output logic [NUM_CH-1:0]                  clk_en,
  output logic [NUM_CH-1:0]                  div_pending
);
  localparam int SEL_W = joy_clk_sel_w(NUM_CH);
  logic wr_ok;
  assign wr_ok = div_wr && (int'(div_sel) < NUM_CH);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    joy_clk_en_channel #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DIV_W'(DEFAULT_DIV))
    ) u_ch (
      .clk_peripheral(clk_peripheral),
      .reset_n       (reset_n),
      .run           (run[i]),
      .restart       (restart),
      .wr            (wr_ok && (div_sel == SEL_W'(i))),
      .wr_data       (div_data),
      .clk_en        (clk_en[i]),
      .pending       (div_pending[i])
    );
  end
endmodule

// File: tb/tb_joy_clock_enable_gen.sv
// tb_joy_clock_enable_gen: randomized scoreboard bench against a behavioural channel model
module tb_joy_clock_enable_gen;
  localparam int N  = 5;
  localparam int W  = 7;
  localparam int DD = 127;
  localparam int SW = 3;
  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   run = '0;
  logic           restart = 1'b0;
  logic           div_wr = 1'b0;
  logic [SW-1:0]  div_sel = '0;
  logic [W-1:0]   div_data = '0;
  logic [N-1:0]   clk_en, div_pending;
  joy_clock_enable_gen #(.NUM_CH(N), .DIV_W(W), .DEFAULT_DIV(DD)) dut (
    .clk_peripheral(clk), .reset_n(reset_n), .run(run), .restart(restart),
    .div_wr(div_wr), .div_sel(div_sel), .div_data(div_data),
    .clk_en(clk_en), .div_pending(div_pending)
  );
  always #5 clk = ~clk;
  // model: "left" running edges before the pulse-producing edge, current and queued periods
  int left[N], per[N], queued[N];
  bit waiting[N];
  logic [2*N-1:0] exp_q[$];
  int checks = 0, passed = 0;
  task automatic cyc(input bit rn, input logic [N-1:0] r, input bit rs,
                     input bit w, input int s, input int d);
    logic [N-1:0] en, pd;
    @(negedge clk);
    reset_n = rn; run = r; restart = rs; div_wr = w; div_sel = SW'(s); div_data = W'(d);
    en = '0;
    for (int c = 0; c < N; c++) begin
      bit hit;
      hit = w && (s == c);
      if (!rn) begin
        left[c] = DD; per[c] = DD; queued[c] = DD; waiting[c] = 0;
      end else if (rs || (r[c] && left[c] == 0)) begin
        en[c] = !rs;
        per[c] = hit ? d : (waiting[c] ? queued[c] : per[c]);
        left[c] = per[c];
        waiting[c] = 0;
        if (hit) queued[c] = d;
      end else if (r[c]) begin
        left[c] = left[c] - 1;
        if (hit) begin queued[c] = d; waiting[c] = 1; end
      end else begin
        if (waiting[c]) begin per[c] = queued[c]; waiting[c] = 0; end
        if (hit) begin queued[c] = d; waiting[c] = 1; end
      end
    end
    for (int c = 0; c < N; c++) pd[c] = waiting[c];
    exp_q.push_back({en, pd});
  endtask
  task automatic idle(input int n, input logic [N-1:0] r);
    for (int k = 0; k < n; k++) cyc(1, r, 0, 0, 0, 0);
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      logic [2*N-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({clk_en, div_pending} === e) passed++;
      else $display("FAIL cycle_out t=%0t clk_en/div_pending got %b/%b want %b/%b",
                    $time, clk_en, div_pending, e[2*N-1:N], e[N-1:0]);
    end
  end
  initial begin
    logic [N-1:0] all1;
    all1 = '1;
    repeat (3) cyc(0, all1, 0, 0, 0, 0);
    idle(300, all1);                       // default /128 pulses at edges 128 and 256
    idle(37, all1);
    cyc(1, all1, 0, 1, 1, 3);              // ch1 D=3 mid-count
    idle(200, all1);
    cyc(1, all1 & ~5'b00100, 0, 1, 2, 0);  // ch2 D=0 while held
    idle(5, all1 & ~5'b00100);
    idle(150, all1);
    cyc(1, all1, 0, 1, 0, 5);
    cyc(1, all1, 0, 1, 1, 5);
    cyc(1, all1, 0, 1, 2, 9);
    cyc(1, all1, 0, 1, 3, 2);
    idle(140, all1);
    cyc(1, all1, 1, 0, 0, 0);              // phase-aligning restart
    idle(40, all1);
    for (int s = N; s < 8; s++) cyc(1, all1, 0, 1, s, 1);
    idle(20, all1);
    for (int k = 0; k < 200 && left[0] != 0; k++) idle(1, all1);
    cyc(1, all1, 0, 1, 0, 7);              // write coincident with ch0 reload
    idle(30, all1);
    cyc(1, all1, 1, 1, 3, 4);              // restart + write together
    idle(20, all1);
    cyc(0, all1, 0, 0, 0, 0);              // one-cycle reset mid-count
    idle(260, all1);
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] r;
      for (int c = 0; c < N; c++) r[c] = ($urandom_range(0, 99) < 85);
      cyc(($urandom_range(0, 399) != 0), r, ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 7) == 0), $urandom_range(0, 7),
          ($urandom_range(0, 9) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 12));
    end
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/joy_clock_enable_gen.md
Name: joy_clock_enable_gen

Overview:
- Parametrised multi-channel clock-enable generator for the joystick and peripheral subsystem, on the peripheral clock.
- Each channel has a programmable divisor and emits a one-cycle clk_en pulse every DIV+1 clocks.
- Divisors can be rewritten at run time without glitches, because writes are shadowed until the next reload.
- Adds per-channel run/hold, a global phase-aligning restart, and a divisor-write port, which the old fixed /128 divider lacks.

Parameters:
- NUM_CH, 4, number of independent enable channels (1..8).
- DIV_W, 7, divisor/counter width in bits.
- DEFAULT_DIV, 127, divisor loaded into every channel at reset. The resulting period is 128 clocks.

Ports:
- clk_peripheral  input  1  peripheral clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- run  input  NUM_CH  per-channel count enable. Low means hold.
- restart  input  1  global re-align. Reloads every channel counter this cycle.
- div_wr  input  1  divisor write strobe, single-cycle, no back-pressure.
- div_sel  input  clog2(NUM_CH) (min 1)  channel index for the write.
- div_data  input  DIV_W  new divisor value D. The period is D+1 clocks.
- clk_en  output  NUM_CH  registered one-cycle enable pulses.
- div_pending  output  NUM_CH  high while a written divisor has not yet reached the active register.

Behaviour:
Per-channel state:
- cnt[DIV_W], div_active[DIV_W], div_shadow[DIV_W], pend (1 bit), clk_en (registered).

Reset (reset_n=0 at a clock edge):
- cnt=DEFAULT_DIV, div_active=div_shadow=DEFAULT_DIV, pend=0, clk_en=0.
- Reset overrides every other input.

Write:
- div_wr=1 with div_sel<NUM_CH: div_shadow[sel]<=div_data and pend[sel]<=1.
- div_sel>=NUM_CH: write ignored, no state change.
- A later write before the transfer overwrites the shadow; last write wins.

Reload event:
- A channel reloads when it is running and cnt==0, or when restart=1.
- On reload: cnt<=(pend ? div_shadow : div_active), div_active<=that same value, pend<=0.
- A write to the same channel in the same cycle as a reload uses div_data directly and leaves pend=0.

Counting, run[i]=1 and no restart:
- cnt!=0: cnt<=cnt-1, clk_en<=0.
- cnt==0: clk_en<=1, reload as above.
- Result: pulse period is exactly div_active+1 clocks. D=0 gives clk_en high every cycle.

Hold, run[i]=0:
- cnt frozen, clk_en<=0.
- If pend=1, the shadow transfers immediately: div_active<=div_shadow, pend<=0. cnt is left frozen.
- Re-asserting run resumes from the frozen cnt.

Restart:
- All channels: cnt reloaded and clk_en<=0, regardless of run.
- The first pulse afterwards appears D+1 running cycles later, so all channels with equal D are phase-aligned.

Timing and boundaries:
- Latency from cnt==0 to clk_en is one clock (output registered).
- The counter wraps only through reload and never underflows.
- After reset release the first pulse is on the DEFAULT_DIV+1th rising edge (128th by default).
- restart, write and cnt==0 together: restart wins for cnt, the written data is used, clk_en=0.
- Reset mid-count: the next edge with reset_n=0 clears all state. No partial pulse.

Decomposition:
- Package joy_clk_pkg holds:
  - constants JOY_CLK_NUM_CH_DEF=4, JOY_CLK_DIV_W_DEF=7, JOY_CLK_DEFAULT_DIV=127;
  - function for the div_sel width (clog2 with minimum 1).
- Sub-module joy_clk_en_channel implements one channel: cnt, div_active, div_shadow, pend and the clk_en register.
  - Its inputs are run, restart, and a wr/data pair already decoded by the top level.
  - The top level performs div_sel decode and range check, and a generate loop over NUM_CH.

Test Plan:
1. Reset then run=all 1 with defaults -> every clk_en[i] first pulses at edge 128, then every 128 clocks, each pulse 1 cycle wide. div_pending=0.
2. Write ch1 D=3 mid-count while running -> div_pending[1]=1 until the current 128-period ends. Then ch1 pulses every 4 clocks and div_pending[1]=0. Other channels are unchanged.
3. Write D=0 to ch2 with run[2]=0 -> div_pending[2] clears next cycle. Raise run[2] -> the old frozen count drains, then clk_en[2] is constantly high.
4. Channels D=5, 5, 9, 2 running freely, pulse restart -> clk_en all 0 that cycle. ch0 and ch1 pulse together 6 clocks later. ch3 first pulses 3 clocks later, ch2 10 clocks later.
5. div_wr with div_sel=NUM_CH (out of range, NUM_CH not a power of 2 variant) -> no div_pending bit set, all periods unchanged. div_wr coincident with ch0 cnt==0 -> the new D takes effect for the very next period, div_pending[0] stays 0.
6. Assert reset_n=0 for one cycle mid-count with D=3 programmed -> all clk_en=0 the next cycle, divisors back to 127, next pulse 128 edges after release.
